// File: rtl/fetch_pkg.sv
// Shared definitions for the five-phase fetch trigger protocol.
// The trigger sequencer and the datapath responder use the same phase enum.
package fetch_pkg;
  localparam int ADDR_W   = 8;
  localparam int DATA_W   = 16;
  localparam int OPCODE_W = 4;
  localparam int COUNT_W  = 16;

  typedef enum logic [2:0] {
    WAIT_LATCH  = 3'd0,
    WAIT_UPDATE = 3'd1,
    WAIT_FETCH  = 3'd2,
    WAIT_DECODE = 3'd3,
    WAIT_OUT    = 3'd4
  } phase_t;

  // One-hot trigger pattern {out, decode, fetch, update, latch} a phase waits for.
  function automatic logic [4:0] phase_mask(input phase_t p);
    case (p)
      WAIT_LATCH:  phase_mask = 5'b00001;
      WAIT_UPDATE: phase_mask = 5'b00010;
      WAIT_FETCH:  phase_mask = 5'b00100;
      WAIT_DECODE: phase_mask = 5'b01000;
      WAIT_OUT:    phase_mask = 5'b10000;
      default:     phase_mask = 5'b00000;
    endcase
  endfunction
endpackage

// File: rtl/fetch_phase_tracker.sv
// Phase tracker for the fetch trigger protocol: accepts only the single
// expected trigger per phase and flags everything else as a violation.
module fetch_phase_tracker
  import fetch_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic latch_trigger,
  input  logic update_pc_trigger,
  input  logic fetch_prog_mem_trigger,
  input  logic decode_instr_trigger,
  input  logic out_latch_trigger,
  output logic accept_latch,
  output logic accept_update,
  output logic accept_fetch,
  output logic accept_decode,
  output logic accept_out,
  output logic violation
);
  phase_t state, state_n;
  logic [4:0] trig;
  logic hit;

  always_ff @(posedge clock) begin
    if (reset) state <= WAIT_LATCH;
    else       state <= state_n;
  end

  always_comb begin
    trig          = {out_latch_trigger, decode_instr_trigger, fetch_prog_mem_trigger,
                     update_pc_trigger, latch_trigger};
    // Exact equality with a one-hot mask also rejects multiple triggers.
    hit           = (trig == phase_mask(state)) && !reset;
    violation     = (trig != 5'd0) && !hit && !reset;
    accept_latch  = hit && (state == WAIT_LATCH);
    accept_update = hit && (state == WAIT_UPDATE);
    accept_fetch  = hit && (state == WAIT_FETCH);
    accept_decode = hit && (state == WAIT_DECODE);
    accept_out    = hit && (state == WAIT_OUT);
    state_n       = state;
    if (violation) state_n = WAIT_LATCH;
    else if (hit) begin
      case (state)
        WAIT_LATCH:  state_n = WAIT_UPDATE;
        WAIT_UPDATE: state_n = WAIT_FETCH;
        WAIT_FETCH:  state_n = WAIT_DECODE;
        WAIT_DECODE: state_n = WAIT_OUT;
        default:     state_n = WAIT_LATCH;
      endcase
    end
  end
endmodule

// File: rtl/fetch_trigger_responder.sv
// Datapath end of the fetch trigger protocol: owns the PC, reads program
// memory, decodes the instruction word and publishes it on out-latch.
module fetch_trigger_responder #(
  parameter int ADDR_W   = fetch_pkg::ADDR_W,
  parameter int DATA_W   = fetch_pkg::DATA_W,
  parameter int OPCODE_W = fetch_pkg::OPCODE_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       latch_trigger,
  input  logic                       update_pc_trigger,
  input  logic                       fetch_prog_mem_trigger,
  input  logic                       decode_instr_trigger,
  input  logic                       out_latch_trigger,
  input  logic                       hold_request,
  input  logic                       jump_valid,
  input  logic [ADDR_W-1:0]          jump_addr,
  output logic [ADDR_W-1:0]          prog_addr,
  output logic                       prog_rd_en,
  input  logic [DATA_W-1:0]          prog_data,
  output logic                       latched_hold,
  output logic [ADDR_W-1:0]          pc,
  output logic [OPCODE_W-1:0]        out_opcode,
  output logic [DATA_W-OPCODE_W-1:0] out_operand,
  output logic                       out_valid,
  output logic [fetch_pkg::COUNT_W-1:0] instr_count,
  output logic                       seq_error
);
  logic acc_latch, acc_update, acc_fetch, acc_decode, acc_out, violation;
  logic [DATA_W-1:0] instr;

  fetch_phase_tracker u_tracker (
    .clock                  (clock),
    .reset                  (reset),
    .latch_trigger          (latch_trigger),
    .update_pc_trigger      (update_pc_trigger),
    .fetch_prog_mem_trigger (fetch_prog_mem_trigger),
    .decode_instr_trigger   (decode_instr_trigger),
    .out_latch_trigger      (out_latch_trigger),
    .accept_latch           (acc_latch),
    .accept_update          (acc_update),
    .accept_fetch           (acc_fetch),
    .accept_decode          (acc_decode),
    .accept_out             (acc_out),
    .violation              (violation)
  );

  // A held sequence still reads memory so the same address is refetched.
  assign prog_rd_en = acc_fetch;
  assign prog_addr  = pc;

  always_ff @(posedge clock) begin
    if (reset) begin
      pc           <= RESET_PC;
      instr        <= '0;
      latched_hold <= 1'b0;
      out_opcode   <= '0;
      out_operand  <= '0;
      out_valid    <= 1'b0;
      instr_count  <= '0;
      seq_error    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (acc_latch) latched_hold <= hold_request;
      if (acc_update && !latched_hold) pc <= jump_valid ? jump_addr : pc + 1'b1;
      if (acc_decode) instr <= prog_data;
      if (acc_out && !latched_hold) begin
        out_opcode  <= instr[DATA_W-1 -: OPCODE_W];
        out_operand <= instr[DATA_W-OPCODE_W-1:0];
        out_valid   <= 1'b1;
        instr_count <= instr_count + 1'b1;
      end
      if (violation) seq_error <= 1'b1;
    end
  end
endmodule

// File: doc/fetch_trigger_responder.md
Name: fetch_trigger_responder

Overview:
- Datapath end of the five-phase fetch trigger protocol: consumes the one-hot trigger pulses latch, update-PC, fetch, decode and out-latch.
- Owns the program counter, drives the program-memory read, captures and decodes the instruction word, and publishes the result on out-latch.
- Also produces the latched_hold stall indication and flags any trigger arriving out of protocol order.

Parameters:
- ADDR_W, 8, program counter / program memory address width
- DATA_W, 16, instruction word width
- OPCODE_W, 4, opcode field width (instruction MSBs); operand = remaining DATA_W-OPCODE_W LSBs
- RESET_PC, 0, PC value loaded on reset

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- latch_trigger  in  1  phase 0 pulse
- update_pc_trigger  in  1  phase 1 pulse
- fetch_prog_mem_trigger  in  1  phase 2 pulse
- decode_instr_trigger  in  1  phase 3 pulse
- out_latch_trigger  in  1  phase 4 pulse
- hold_request  in  1  stall request, sampled only on latch_trigger
- jump_valid  in  1  load jump_addr instead of PC+1, sampled only on update_pc_trigger
- jump_addr  in  ADDR_W  jump target
- prog_addr  out  ADDR_W  program memory address (= pc register)
- prog_rd_en  out  1  program memory read strobe
- prog_data  in  DATA_W  program memory read data, valid the cycle after prog_rd_en, held until the next read
- latched_hold  out  1  registered hold for the current sequence
- pc  out  ADDR_W  current program counter
- out_opcode  out  OPCODE_W  published opcode
- out_operand  out  DATA_W-OPCODE_W  published operand
- out_valid  out  1  one-cycle pulse: new instruction published
- instr_count  out  16  instructions published, wraps 0xFFFF->0
- seq_error  out  1  sticky protocol-violation flag

Behaviour:
- Reset (synchronous, highest priority, accepted mid-sequence):
  - pc=RESET_PC; instr/opcode/operand regs, out_*, latched_hold, instr_count, seq_error = 0.
  - Phase tracker returns to WAIT_LATCH; triggers sampled in the reset cycle are ignored.
- Phase tracker FSM: WAIT_LATCH -> WAIT_UPDATE -> WAIT_FETCH -> WAIT_DECODE -> WAIT_OUT -> WAIT_LATCH.
  - Advances only on the matching single trigger.
  - Gaps of any length between triggers are legal; no timeout.
- Violation: a non-matching trigger, or two or more triggers high in one cycle.
  - Sets seq_error (stays set until reset) and forces WAIT_LATCH.
  - The offending cycle performs no datapath action.
  - A lone latch_trigger in the violation cycle is also discarded; the next latch_trigger restarts normally.
- WAIT_LATCH + latch_trigger: latched_hold <= hold_request.
- WAIT_UPDATE + update_pc_trigger:
  - latched_hold=1: pc unchanged, jump_valid ignored.
  - jump_valid=1: pc <= jump_addr.
  - Otherwise pc <= pc+1, modulo 2^ADDR_W (max wraps to 0).
- WAIT_FETCH + fetch_prog_mem_trigger:
  - prog_rd_en = fetch_prog_mem_trigger AND tracker in WAIT_FETCH (combinational, same cycle); prog_addr = pc.
  - prog_rd_en is asserted even when held (refetch of the same address).
- WAIT_DECODE + decode_instr_trigger:
  - instr reg <= prog_data.
  - opcode/operand split registered in the same edge: opcode = instr[DATA_W-1 -: OPCODE_W], operand = low bits.
- WAIT_OUT + out_latch_trigger:
  - latched_hold=0: out_opcode/out_operand <= decoded values; out_valid=1 for exactly the next cycle; instr_count+1.
  - latched_hold=1: outputs unchanged, out_valid stays 0, count unchanged.
- Latency: out_valid high the cycle after out_latch_trigger; minimum full sequence 5 cycles.

Decomposition:
- Shared package (fetch_pkg) holds:
  - phase enum: WAIT_LATCH..WAIT_OUT
  - default widths: ADDR_W, DATA_W, OPCODE_W
  - COUNT_W=16
  - The trigger sequencer and this block import the same enum.
- One sub-module: fetch_phase_tracker, containing the FSM plus violation detection.
  - Outputs: per-phase accept strobes and the error pulse.
  - Parent holds PC, instruction, output and count registers.

Test Plan:
- Reset, then 5 back-to-back triggers, no hold/jump, memory[0]=0xA123 -> prog_rd_en high with prog_addr=1 in fetch cycle; with memory[1]=0x5BCD, out_opcode=0x5, out_operand=0xBCD, out_valid one cycle, instr_count=1.
- PC wrap: pc=0xFF, no jump, update trigger -> pc=0x00; a following sequence fetches address 0.
- Jump: jump_valid=1, jump_addr=0x40 at update trigger -> pc=0x40, prog_addr=0x40 at fetch; jump_valid at any other phase has no effect.
- Hold: hold_request=1 at latch -> latched_hold=1, pc unchanged, rd_en still pulses, no out_valid, count unchanged; next sequence with hold_request=0 resumes normally.
- Order violation: decode_instr_trigger while WAIT_UPDATE -> seq_error=1, pc and outputs unchanged; next latch-start sequence completes, seq_error remains 1.
- Simultaneous triggers (fetch+decode same cycle) -> seq_error=1, prog_rd_en=0; reset mid-sequence (in WAIT_DECODE) -> all outputs to reset values, pc=RESET_PC, seq_error=0.
